// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle: ID/EX operand info, branch and
// data-memory status in; pipeline register enables, flushes and status out.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_memread;
    logic             ex_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    // pipeline side
    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_ex_rd, id_ex_memread, ex_branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout, stall_cycles
    );

    // hazard unit side
    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_ex_rd, id_ex_memread, ex_branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush, data-memory
// wait with timeout into a sticky error state, and a saturating stall counter.
module hazard_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);
    localparam int WCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t           state, state_nxt;
    logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    logic load_use, mem_stall, eval;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic id_ex_bubble, if_id_flush, id_ex_flush;

    assign load_use = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.id_ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.id_ex_rd)));
    assign mem_stall = hz.dmem_req && !hz.dmem_ready;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        eval         = 1'b0;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WCW'(1);
                end else begin
                    eval = 1'b1;
                end
            end
            WAIT: begin
                // EX is frozen while waiting, so a pending branch is acted on at release
                if (!hz.dmem_ready) begin
                    if (wait_cnt == WAIT_MAX) state_nxt = ERR;
                    else                      wait_cnt_nxt = wait_cnt + 1'b1;
                end else begin
                    eval         = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            ERR:     ;
            default: state_nxt = RUN;
        endcase

        if (eval) begin
            if (hz.ex_branch_taken) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (load_use) begin
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                id_ex_bubble = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ERR) mem_timeout <= 1'b1;
            if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.id_ex_write  = id_ex_write;
    assign hz.ex_mem_write = ex_mem_write;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.mem_timeout  = mem_timeout;
    assign hz.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: per-cycle comparison against a behavioural
// model plus hand-computed literal checks on the key scenarios.
module tb_hazard_unit;
    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hazard_unit_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: how many consecutive cycles the current memory access has been
    // blocking, whether the timeout has fired, and the stall total.
    int m_out = 0, n_out = 0;
    bit m_dead = 0, n_dead = 0;
    int m_stalls = 0, n_stalls = 0;

    always @(negedge clk) begin
        bit lu, blocked;
        bit e_pc, e_ifid, e_idex, e_exmem, e_bub, e_iff, e_idf;
        {e_pc, e_ifid, e_idex, e_exmem, e_bub, e_iff, e_idf} = '0;
        lu = hz.id_ex_memread && hz.id_ex_rd != 0 &&
             ((hz.id_uses_rs1 && hz.id_rs1_addr == hz.id_ex_rd) ||
              (hz.id_uses_rs2 && hz.id_rs2_addr == hz.id_ex_rd));
        n_out = m_out; n_dead = m_dead; n_stalls = m_stalls;
        if (!rst_n) begin
            n_out = 0; n_dead = 0; n_stalls = 0;
        end else if (!m_dead) begin
            blocked = !hz.dmem_ready && (hz.dmem_req || m_out > 0);
            if (blocked) begin
                if (m_out == TO) n_dead = 1;
                n_out = m_out + 1;
            end else begin
                n_out = 0;
                if (hz.ex_branch_taken) {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf} = '1;
                else if (lu)            {e_idex, e_exmem, e_bub} = '1;
                else                    {e_pc, e_ifid, e_idex, e_exmem} = '1;
            end
        end
        if (rst_n && !e_pc && m_stalls < SMAX) n_stalls = m_stalls + 1;
        chk("pc_write",     hz.pc_write,     e_pc);
        chk("if_id_write",  hz.if_id_write,  e_ifid);
        chk("id_ex_write",  hz.id_ex_write,  e_idex);
        chk("ex_mem_write", hz.ex_mem_write, e_exmem);
        chk("id_ex_bubble", hz.id_ex_bubble, e_bub);
        chk("if_id_flush",  hz.if_id_flush,  e_iff);
        chk("id_ex_flush",  hz.id_ex_flush,  e_idf);
        chk("mem_timeout",  hz.mem_timeout,  m_dead);
        chk("stall_cycles", hz.stall_cycles, m_stalls);
    end

    always @(posedge clk) begin
        m_out    <= n_out;
        m_dead   <= n_dead;
        m_stalls <= n_stalls;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_rs1_addr = 5'd1; hz.id_rs2_addr = 5'd2;
        hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
        hz.id_ex_rd = 5'd0; hz.id_ex_memread = 1'b0;
        hz.ex_branch_taken = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
        hz.id_ex_memread = 1'b1; hz.id_ex_rd = rd;
        hz.id_rs1_addr = r1; hz.id_uses_rs1 = u1;
        hz.id_rs2_addr = r2; hz.id_uses_rs2 = u2;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        // reset: outputs held low, registers cleared
        chk("rst_pc_write", hz.pc_write, 0);
        tick(); tick();
        chk("rst_stall", hz.stall_cycles, 0);
        chk("rst_timeout", hz.mem_timeout, 0);
        rst_n = 1'b1;
        #1 chk("idle_pc_write", hz.pc_write, 1);
        tick();

        // lw x5 in EX, add uses x5 as rs2
        load(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
        #1;
        chk("lu_pc_write", hz.pc_write, 0);
        chk("lu_if_id_write", hz.if_id_write, 0);
        chk("lu_bubble", hz.id_ex_bubble, 1);
        chk("lu_id_ex_write", hz.id_ex_write, 1);
        tick();
        idle();
        #1;
        chk("lu_stall_cnt", hz.stall_cycles, 1);
        chk("lu_one_cycle", hz.pc_write, 1);
        tick();

        // load to x0 never stalls; unused operand match never stalls
        load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 chk("x0_no_stall", hz.pc_write, 1);
        tick();
        load(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        #1 chk("unused_rs2", hz.pc_write, 1);
        tick();
        load(5'd7, 5'd7, 1'b1, 5'd9, 1'b1);
        tick();

        // branch wins over load-use
        load(5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
        hz.ex_branch_taken = 1'b1;
        #1;
        chk("br_if_id_flush", hz.if_id_flush, 1);
        chk("br_id_ex_flush", hz.id_ex_flush, 1);
        chk("br_pc_write", hz.pc_write, 1);
        chk("br_bubble", hz.id_ex_bubble, 0);
        tick();
        idle();

        // clean count for the memory-wait case
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_pc_write", hz.pc_write, 0);
            tick();
        end
        hz.dmem_ready = 1'b1;
        #1 chk("mw_release", hz.pc_write, 1);
        tick();
        idle();
        #1 chk("mw_stall_cnt", hz.stall_cycles, 3);
        chk("mw_back_run", hz.pc_write, 1);
        tick();

        // branch during wait flushes only at release; release with load-use
        hz.dmem_req = 1'b1;
        tick();
        hz.ex_branch_taken = 1'b1;
        #1 chk("wait_br_noflush", hz.if_id_flush, 0);
        tick();
        hz.dmem_ready = 1'b1;
        #1 chk("wait_br_release", hz.id_ex_flush, 1);
        tick();
        idle();
        hz.dmem_req = 1'b1;
        tick();
        hz.dmem_ready = 1'b1;
        load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        #1 chk("wait_lu_release", hz.id_ex_bubble, 1);
        tick();
        idle();
        tick();

        // timeout: 1 RUN stall cycle + TO wait cycles, then sticky ERR
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 0; i < TO + 1; i++) begin
            #1 chk("to_not_yet", hz.mem_timeout, 0);
            tick();
        end
        #1 chk("to_fired", hz.mem_timeout, 1);
        hz.dmem_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("err_sticky", hz.mem_timeout, 1);
        chk("err_pc_write", hz.pc_write, 0);
        chk("stall_saturate", hz.stall_cycles, SMAX);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        idle();
        #1 chk("err_rst_timeout", hz.mem_timeout, 0);
        chk("err_rst_run", hz.pc_write, 1);
        tick();

        // reset in the middle of a wait aborts to RUN
        hz.dmem_req = 1'b1;
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        idle();
        #1 chk("midwait_rst", hz.pc_write, 1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum data-memory wait cycles before an error.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 id_rs1_addr, id_rs2_addr  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-007 id_ex_rd  input  5  destination register of the instruction in EX.
REQ-008 id_ex_memread  input  1  EX instruction is a load.
REQ-009 ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-010 dmem_req, dmem_ready  input  1 each  MEM-stage access pending / data memory completes this cycle.
REQ-011 pc_write, if_id_write, id_ex_write, ex_mem_write  output  1 each  pipeline register enables; 1 = advance.
REQ-012 id_ex_bubble  output  1  load ID/EX with a NOP (control signals zeroed).
REQ-013 if_id_flush, id_ex_flush  output  1 each  squash the IF/ID and ID/EX contents.
REQ-014 mem_timeout  output  1  sticky error flag.
REQ-015 stall_cycles  output  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-016 FSM states SHALL be RUN, WAIT, ERR; outputs combinational from state and inputs; state, wait_cnt, mem_timeout and stall_cycles registered.
REQ-017 load_use SHALL be 1 when id_ex_memread=1, id_ex_rd!=0, and (id_uses_rs1 and id_rs1_addr==id_ex_rd) or (id_uses_rs2 and id_rs2_addr==id_ex_rd).
REQ-018 mem_stall SHALL be 1 when dmem_req=1 and dmem_ready=0.
REQ-019 Priority in RUN SHALL be mem_stall > ex_branch_taken > load_use > normal.
REQ-020 RUN with mem_stall: all four enables 0, no flush, no bubble; next state WAIT, wait_cnt<=1.
REQ-021 RUN with ex_branch_taken, no mem_stall: enables 1, if_id_flush=1, id_ex_flush=1, id_ex_bubble=0; load_use ignored that cycle.
REQ-022 RUN with load_use only: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1, ex_mem_write=1; stall lasts exactly one cycle with no state kept.
REQ-023 RUN otherwise: all enables 1, flush and bubble 0.
REQ-024 WAIT with dmem_ready=0: all enables 0; wait_cnt increments; if wait_cnt==TIMEOUT_CYCLES, next state ERR.
REQ-025 WAIT with dmem_ready=1: outputs as RUN-priority evaluation excluding mem_stall; next state RUN, wait_cnt<=0.
REQ-026 A branch taken arriving during WAIT SHALL NOT flush until the release cycle; EX is frozen, so the input is held.
REQ-027 ERR: all enables 0, flushes 0, mem_timeout=1; remain in ERR until reset.
REQ-028 stall_cycles SHALL increment in every cycle with rst_n=1 and pc_write=0, and saturate at 2^CNT_W-1.
REQ-029 wait_cnt SHALL be wide enough for TIMEOUT_CYCLES; no wrap.

Reset
REQ-030 While rst_n=0, all enables, flushes and id_ex_bubble SHALL be 0.
REQ-031 At a clock edge with rst_n=0: state<=RUN, wait_cnt<=0, mem_timeout<=0, stall_cycles<=0; reset mid-WAIT or in ERR aborts to RUN.

Verification
REQ-032 EX: lw x5, memread=1; ID: add with rs2=x5, uses_rs2=1 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1.
REQ-033 Load to x0 with ID rs1=x0 -> no stall; all enables 1.
REQ-034 dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, 1 on 4th; state back to RUN; stall_cycles=3.
REQ-035 ex_branch_taken=1 together with load_use -> if_id_flush=id_ex_flush=1, pc_write=1, id_ex_bubble=0.
REQ-036 TIMEOUT_CYCLES=4, dmem_ready held 0 -> ERR after 4 wait cycles, mem_timeout=1 sticky; rst_n=0 one edge -> mem_timeout=0, state RUN.
